// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution accumulator.
// Used by conv_accumulator; the CONV_ACC_SATURATE_EN build relies on fit_sat().
package conv_pkg;

  // Widest value the helper functions below can handle.
  localparam int unsigned MAX_W = 256;

  typedef enum logic [0:0] {ST_IDLE, ST_ACCUM} conv_state_e;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Clamp an unsigned w_in-bit value to the largest w_out-bit value.
  function automatic logic [MAX_W-1:0] fit_sat(input logic [MAX_W-1:0] val,
                                               input int unsigned w_in,
                                               input int unsigned w_out);
    logic [MAX_W-1:0] v;
    logic [MAX_W-1:0] lim;
    v   = val & width_mask(w_in);
    lim = width_mask(w_out);
    return (v > lim) ? lim : v;
  endfunction

  // True when narrowing a w_in-bit value to w_out bits drops a nonzero bit.
  function automatic logic fit_loss(input logic [MAX_W-1:0] val,
                                    input int unsigned w_in,
                                    input int unsigned w_out);
    logic [MAX_W-1:0] v;
    v = val & width_mask(w_in);
    return (v >> w_out) != '0;
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// Product-stream input and result output of the convolution accumulator.
interface conv_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] in_prod;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic [CNT_WIDTH-1:0]    out_count;
  logic                    out_ovf;

  // Environment side: feeds products and drains results.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/acc_out_reg.sv
// One-entry valid/ready output register; in_ready tells the producer a load is possible.
module acc_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             in_ready
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // load is only raised while in_ready is high, so a held entry is never overwritten.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Sums the product beats of one convolution window and emits one result per window.
// Define CONV_ACC_SATURATE_EN to clamp the accumulator and the output instead of wrapping.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GUARD_BITS = 8,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  conv_accumulator_if.slave    bus
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, GUARD_BITS);
  localparam int unsigned RES_WIDTH = OUT_WIDTH + CNT_WIDTH + 1;

  conv_state_e          state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 add_ovf;
  logic                 narrow_loss;
  logic [OUT_WIDTH-1:0] fit_data;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [RES_WIDTH-1:0] res_d;
  logic [RES_WIDTH-1:0] res_q;
  logic                 in_ready;
  logic                 accept;
  logic                 close;

  assign accept = bus.in_valid && in_ready;
  // A flushed beat is consumed but never closes a window.
  assign close  = accept && bus.in_last && !flush;

  always_comb begin
    base    = (state_q == ST_ACCUM) ? acc_q : '0;
    sum     = {1'b0, base} + (ACC_WIDTH+1)'(bus.in_prod);
    add_ovf = sum[ACC_WIDTH];
`ifdef CONV_ACC_SATURATE_EN
    acc_next = add_ovf ? '1 : sum[ACC_WIDTH-1:0];
    fit_data = OUT_WIDTH'(fit_sat(MAX_W'(acc_next), ACC_WIDTH, OUT_WIDTH));
`else
    acc_next = sum[ACC_WIDTH-1:0];
    fit_data = acc_next[OUT_WIDTH-1:0];
`endif
    narrow_loss = fit_loss(MAX_W'(acc_next), ACC_WIDTH, OUT_WIDTH);
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    res_d       = {ovf_q | add_ovf | narrow_loss, cnt_inc, fit_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= ST_ACCUM;
        acc_q   <= acc_next;
        cnt_q   <= cnt_inc;
        ovf_q   <= ovf_q | add_ovf;
      end
    end
  end

  acc_out_reg #(
    .WIDTH(RES_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (close),
    .load_data(res_d),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_data (res_q),
    .in_ready (in_ready)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = res_q[OUT_WIDTH-1:0];
  assign bus.out_count = res_q[OUT_WIDTH +: CNT_WIDTH];
  assign bus.out_ovf   = res_q[RES_WIDTH-1];

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: one instance with guard bits, one without for acc overflow.
module tb_conv_accumulator;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 16;
  localparam int unsigned CW = 16;
`ifdef CONV_ACC_SATURATE_EN
  localparam logic [63:0] OVF_EXP = 64'd65535;
`else
  localparam logic [63:0] OVF_EXP = 64'd64514;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic flush_a;
  logic flush_b;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  conv_accumulator_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus_a ();
  conv_accumulator_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus_b ();

  conv_accumulator #(
    .DATA_WIDTH(DW), .GUARD_BITS(8), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush_a),
    .bus  (bus_a)
  );

  conv_accumulator #(
    .DATA_WIDTH(DW), .GUARD_BITS(0), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush_b),
    .bus  (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [2*DW-1:0] prod, input logic last);
    bus_a.in_valid = 1'b1;
    bus_a.in_prod  = prod;
    bus_a.in_last  = last;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic beat_b(input logic [2*DW-1:0] prod, input logic last);
    bus_b.in_valid = 1'b1;
    bus_b.in_prod  = prod;
    bus_b.in_last  = last;
    tick();
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_prod = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_prod = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_data",  64'(bus_a.out_data),  64'd0);
    check("rst_count", 64'(bus_a.out_count), 64'd0);
    check("rst_ovf",   64'(bus_a.out_ovf),   64'd0);
    #21 rstn = 1'b1;
    tick();
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);

    // 4-beat window, result one cycle after the last beat
    beat_a(16'd10, 1'b0);
    beat_a(16'd20, 1'b0);
    beat_a(16'd30, 1'b0);
    check("w1_no_early_valid", 64'(bus_a.out_valid), 64'd0);
    beat_a(16'd40, 1'b1);
    check("w1_valid", 64'(bus_a.out_valid), 64'd1);
    check("w1_data",  64'(bus_a.out_data),  64'd100);
    check("w1_count", 64'(bus_a.out_count), 64'd4);
    check("w1_ovf",   64'(bus_a.out_ovf),   64'd0);

    // Backpressure: result held, next window stalls
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_prod   = 16'd5;
    bus_a.in_last   = 1'b0;
    #1;
    check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(bus_a.in_ready),  64'd0);
      check("bp_valid",    64'(bus_a.out_valid), 64'd1);
      check("bp_data",     64'(bus_a.out_data),  64'd100);
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus_a.in_ready), 64'd1);
    tick();
    check("bp_drained", 64'(bus_a.out_valid), 64'd0);
    bus_a.in_valid = 1'b0;
    beat_a(16'd6, 1'b0);
    beat_a(16'd7, 1'b1);
    check("w2_valid", 64'(bus_a.out_valid), 64'd1);
    check("w2_data",  64'(bus_a.out_data),  64'd18);
    check("w2_count", 64'(bus_a.out_count), 64'd3);

    // Back-to-back single-beat windows, no bubble
    beat_a(16'd7, 1'b1);
    check("b2b1_valid", 64'(bus_a.out_valid), 64'd1);
    check("b2b1_data",  64'(bus_a.out_data),  64'd7);
    check("b2b1_count", 64'(bus_a.out_count), 64'd1);
    beat_a(16'd9, 1'b1);
    check("b2b2_valid", 64'(bus_a.out_valid), 64'd1);
    check("b2b2_data",  64'(bus_a.out_data),  64'd9);
    check("b2b2_count", 64'(bus_a.out_count), 64'd1);
    tick();
    check("b2b_idle", 64'(bus_a.out_valid), 64'd0);

    // Narrowing loss: 130050 fits the 24-bit accumulator but not 16 output bits
    beat_a(16'd65025, 1'b0);
    beat_a(16'd65025, 1'b1);
    check("narrow_data",  64'(bus_a.out_data),  OVF_EXP);
    check("narrow_count", 64'(bus_a.out_count), 64'd2);
    check("narrow_ovf",   64'(bus_a.out_ovf),   64'd1);

    // Accumulator overflow with no guard bits
    beat_b(16'd65025, 1'b0);
    beat_b(16'd65025, 1'b1);
    check("accovf_valid", 64'(bus_b.out_valid), 64'd1);
    check("accovf_data",  64'(bus_b.out_data),  OVF_EXP);
    check("accovf_ovf",   64'(bus_b.out_ovf),   64'd1);
    tick();

    // flush discards the partial window and a same-cycle last beat
    beat_a(16'd5, 1'b0);
    beat_a(16'd6, 1'b0);
    flush_a = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_prod  = 16'd100;
    bus_a.in_last  = 1'b1;
    tick();
    flush_a = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    check("flush_no_result", 64'(bus_a.out_valid), 64'd0);
    beat_a(16'd3, 1'b1);
    check("flush_data",  64'(bus_a.out_data),  64'd3);
    check("flush_count", 64'(bus_a.out_count), 64'd1);
    check("flush_ovf",   64'(bus_a.out_ovf),   64'd0);
    bus_a.out_ready = 1'b0;
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("flush_keeps_valid", 64'(bus_a.out_valid), 64'd1);
    check("flush_keeps_data",  64'(bus_a.out_data),  64'd3);
    bus_a.out_ready = 1'b1;
    tick();
    check("flush_drained", 64'(bus_a.out_valid), 64'd0);

    // Async reset mid-window
    beat_a(16'd50, 1'b1);
    check("pre_rst_data", 64'(bus_a.out_data), 64'd50);
    beat_a(16'd11, 1'b0);
    beat_a(16'd12, 1'b0);
    #3 rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_data",  64'(bus_a.out_data),  64'd0);
    check("mid_rst_count", 64'(bus_a.out_count), 64'd0);
    check("mid_rst_ovf",   64'(bus_a.out_ovf),   64'd0);
    #2 rstn = 1'b1;
    tick();
    beat_a(16'd4, 1'b1);
    check("post_rst_valid", 64'(bus_a.out_valid), 64'd1);
    check("post_rst_data",  64'(bus_a.out_data),  64'd4);
    check("post_rst_count", 64'(bus_a.out_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Downstream stage of the product multiplier. Consumes the stream of unsigned 2*DATA_WIDTH products that make up one convolution window and sums them.
- Emits one accumulated result per window on a valid/ready output port. This output feeds the output-feature buffer.
- Holds one result in an output register. It back-pressures the product stream when that register is occupied and not being drained.

Parameters:
- DATA_WIDTH, 32: operand width of the upstream multiplier; products are 2*DATA_WIDTH bits.
- GUARD_BITS, 8: extra accumulator headroom bits. ACC_WIDTH = 2*DATA_WIDTH+GUARD_BITS.
- OUT_WIDTH, 64: width of out_data. Must be <= ACC_WIDTH.
- CNT_WIDTH, 16: width of the beat counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards the partial window
- in_valid  in  1  product beat valid
- in_ready  out  1  stage can accept a beat
- in_prod  in  2*DATA_WIDTH  unsigned product
- in_last  in  1  marks the final product of a window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_WIDTH  window sum
- out_count  out  CNT_WIDTH  number of beats in the window
- out_ovf  out  1  window sum exceeded ACC_WIDTH or OUT_WIDTH

Behaviour:
- Reset (rstn low, asynchronous): acc=0, beat_cnt=0, ovf_acc=0, state=IDLE.
  - Outputs during reset: out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - in_ready=1 on the first cycle after reset release.
- Reset mid-window: the partial sum is lost and no result is emitted.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
  - A beat is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - out_data, out_count and out_ovf are stable while out_valid=1 && !out_ready.
- States:
  - IDLE: no partial window.
  - ACCUM: partial window held in acc.
  - Transitions: IDLE to ACCUM on an accepted beat with in_last=0. ACCUM to IDLE on an accepted beat with in_last=1. An accepted beat with in_last=1 in IDLE is a single-beat window and stays in IDLE.
- Accumulation:
  - Base value: base = 0 in IDLE, acc in ACCUM.
  - Sum: sum = base + zero-extended in_prod, computed at ACC_WIDTH+1 bits.
  - Overflow: bit ACC_WIDTH of sum sets ovf_acc, which is sticky within the window. acc keeps the low ACC_WIDTH bits, so it wraps.
  - beat_cnt increments on every accepted beat and saturates at all-ones.
- Window close (accepted beat with in_last=1):
  - On the next edge: out_valid=1, out_data=fit(sum), out_count=beat_cnt+1, out_ovf=ovf_acc | overflow of the final add | narrowing loss.
  - acc, beat_cnt and ovf_acc clear.
  - Latency: 1 cycle from the last beat to out_valid.
- Narrowing fit() without SATURATE_EN: low OUT_WIDTH bits. Narrowing loss means any nonzero dropped bit.
- Simultaneous events:
  - Output transfer and a new last beat in the same cycle: the new result loads and out_valid stays 1 with no bubble.
  - Output transfer with no new last beat: out_valid goes to 0.
- flush:
  - Clears acc, beat_cnt and ovf_acc, and returns state to IDLE.
  - Does not drop a pending out_valid result.
  - Takes priority over a beat accepted in the same cycle; that beat is discarded and in_last is ignored.
- Zero-beat windows are impossible; no output is generated without a beat.

Optional Feature:
- Macro: CONV_ACC_SATURATE_EN.
- Defined:
  - acc saturates at 2^ACC_WIDTH-1 instead of wrapping. It stays there for the rest of the window and ovf_acc is set.
  - fit() clamps to 2^OUT_WIDTH-1 when the value does not fit in OUT_WIDTH bits.
  - out_ovf is set whenever any clamp occurred.
- Undefined: wrap-around as described in Behaviour, with out_ovf still reported.

Decomposition:
- Shared package conv_pkg:
  - ACC_WIDTH derivation function.
  - State enum {ST_IDLE, ST_ACCUM}.
  - Saturating-fit function (unsigned value, width in, width out).
- Sub-module acc_out_reg: one-entry valid/ready output register that produces in_ready.
- Everything else stays in conv_accumulator.

Test Plan:
- Reset then 4-beat window: DATA_WIDTH=8, products 10, 20, 30, 40 with last on beat 4. Expect out_data=100, out_count=4, out_ovf=0, and out_valid exactly 1 cycle after beat 4.
- Backpressure: hold out_ready=0 for 5 cycles with the next window streaming. Expect in_ready=0, out_data=100 stable, and no beats lost. Then release and expect the next sum correct.
- Back-to-back single-beat windows with out_ready=1: products 7, 9 with last every beat. Expect out_valid continuously 1, results 7 then 9, out_count=1 for each.
- Overflow: DATA_WIDTH=8, GUARD_BITS=0, OUT_WIDTH=16; two beats of 65025.
  - Without the macro: out_data=64514 (130050 mod 65536), out_ovf=1.
  - With CONV_ACC_SATURATE_EN: out_data=65535, out_ovf=1.
- flush after 2 beats (5, 6), then a window of 3 with last. Expect out_data=3, out_count=1.
- Mid-window async reset: assert rstn=0 after 2 beats. Expect all outputs to be 0 immediately. The next window sum must contain no stale partial sum.
